// File: rtl/regfile_pkg.sv
// Shared defaults and clear-engine state type for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: array mux, zero-register force, optional write bypass.
// Forwarding of same-edge writes is compiled in with REGFILE_BYPASS_EN.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rd_en,
  input  logic [ADDR_W-1:0]                 rd_addr,
  input  logic [(DATA_W << ADDR_W)-1:0]     mem_flat,
  input  logic                              clearing,
  input  logic                              wr0_en,
  input  logic [ADDR_W-1:0]                 wr0_addr,
  input  logic [DATA_W-1:0]                 wr0_data,
  input  logic                              wr1_en,
  input  logic [ADDR_W-1:0]                 wr1_addr,
  input  logic [DATA_W-1:0]                 wr1_data,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              rd_valid
);

  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              zero_hit;

  assign zero_hit = (ZERO_REG != 0) && (rd_addr == '0);

  always_comb begin
    sel_data = mem_flat[rd_addr*DATA_W +: DATA_W];
`ifdef REGFILE_BYPASS_EN
    // Port 1 wins a dual-port match, mirroring write arbitration.
    if (wr1_en && (wr1_addr == rd_addr)) begin
      sel_data = wr1_data;
    end else if (wr0_en && (wr0_addr == rd_addr)) begin
      sel_data = wr0_data;
    end
`endif
    if (clearing || zero_hit) begin
      sel_data = '0;
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data};
`endif

  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? sel_data : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, dual write arbitration, sequenced clear engine.
// Same-edge write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
//
// state | meaning
// IDLE  | normal operation, writes commit
// CLEAR | zeroing entry[clr_cnt] each cycle, writes dropped, reads return 0
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       clr,
  output logic                       clr_busy,
  output logic                       wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DATA_W-1:0]       mem_d [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_busy_q, clr_busy_d;
  logic              wr_drop_q, wr_drop_d;
  logic              clearing;
  logic              wr0_ok, wr1_ok;

  assign clearing = (state_q == CLEAR);
  assign wr0_ok   = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
  assign wr1_ok   = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    mem_d = mem_q;
    if (clearing) begin
      mem_d[clr_cnt_q] = '0;
    end else begin
      if (wr0_ok) mem_d[wr0_addr] = wr0_data;
      if (wr1_ok) mem_d[wr1_addr] = wr1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_drop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        wr_drop_d = wr0_en || wr1_en;
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end
    endcase
    clr_busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_busy_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_busy_q <= clr_busy_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  assign clr_busy = clr_busy_q;
  assign wr_drop  = wr_drop_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign mem_flat[i*DATA_W +: DATA_W] = mem_q[i];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en[k]),
      .rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
      .mem_flat (mem_flat),
      .clearing (clearing),
      .wr0_en   (wr0_en),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .rd_data  (rd_data[k*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp with four read ports; tracks REGFILE_BYPASS_EN.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic           clk;
  logic           rst_n;
  logic [NR-1:0]  rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]  rd_valid;
  logic           wr0_en, wr1_en;
  logic [AW-1:0]  wr0_addr, wr1_addr;
  logic [DW-1:0]  wr0_data, wr1_data;
  logic           clr;
  logic           clr_busy;
  logic           wr_drop;

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .clr      (clr),
    .clr_busy (clr_busy),
    .wr_drop  (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mdl [32];
  logic [DW-1:0] last_exp [NR];
  logic [DW-1:0] sb [$];
  bit            mbusy;
  int            mcnt;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int k = 0; k < NR; k++) last_exp[k] = '0;
    sb.delete();
    mbusy = 1'b0;
    mcnt  = 0;
  endtask

  task automatic idle_inputs();
    rd_en = '0; rd_addr = '0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    clr = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_en[k] = 1'b1;
    rd_addr[k*AW +: AW] = a;
  endtask

  // Inputs are set by the caller after a negedge; one clock is applied here.
  task automatic step();
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    logic [NR-1:0] ev;
    logic ed, eb;
    for (int k = 0; k < NR; k++) begin
      if (rd_en[k]) begin
        a = rd_addr[k*AW +: AW];
        e = (mbusy || a == '0) ? '0 : mdl[a];
`ifdef REGFILE_BYPASS_EN
        if (!mbusy && a != '0) begin
          if (wr1_en && wr1_addr == a) e = wr1_data;
          else if (wr0_en && wr0_addr == a) e = wr0_data;
        end
`endif
        last_exp[k] = e;
      end
      sb.push_back(last_exp[k]);
    end
    ev = rd_en;
    ed = mbusy && (wr0_en || wr1_en);
    if (mbusy) begin
      mdl[mcnt] = '0;
      if (mcnt == 31) begin
        mbusy = 1'b0;
        mcnt  = 0;
      end else begin
        mcnt++;
      end
    end else begin
      if (wr0_en && wr0_addr != '0) mdl[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != '0) mdl[wr1_addr] = wr1_data;
      if (clr) begin
        mbusy = 1'b1;
        mcnt  = 0;
      end
    end
    eb = mbusy;
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(ev));
    chk("wr_drop", 32'(wr_drop), 32'(ed));
    chk("clr_busy", 32'(clr_busy), 32'(eb));
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rd_data%0d", k), rd_data[k*DW +: DW], sb.pop_front());
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic read_all();
    for (int a = 0; a < 32; a += NR) begin
      for (int k = 0; k < NR; k++) set_rd(k, 5'(a + k));
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_wr_drop", 32'(wr_drop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // all entries zero out of reset, rotated across ports
    for (int a = 0; a < 32; a++) begin
      for (int k = 0; k < NR; k++) set_rd(k, 5'((a + k) % 32));
      step();
    end

    // dual-port collision, port 1 wins
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    wr1_en = 1; wr1_addr = 5; wr1_data = 32'h12345678;
    step();
    set_rd(0, 5); set_rd(1, 5);
    step();

    // zero register ignores writes on both ports
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
    step();
    wr1_en = 1; wr1_addr = 0; wr1_data = 32'hFFFFFFFF;
    step();
    set_rd(0, 0); set_rd(3, 0);
    step();

    // same-edge write/read on r7, then confirm stored value
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'hA5A5A5A5;
    set_rd(0, 7); set_rd(2, 7);
    step();
    set_rd(1, 7);
    step();

    // same-edge read with both ports hitting r9; r0 read alongside a write to r0
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h11111111;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h22222222;
    set_rd(0, 9);
    step();
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hCAFEF00D;
    set_rd(1, 0); set_rd(2, 9);
    step();

    // rd_en low holds data; only port 3 reads
    set_rd(3, 5);
    step();

    // fill with index+1
    for (int i = 0; i < 16; i++) begin
      wr0_en = 1; wr0_addr = 5'(2*i);     wr0_data = 32'(2*i + 1);
      wr1_en = 1; wr1_addr = 5'(2*i + 1); wr1_data = 32'(2*i + 2);
      step();
    end
    read_all();

    // sequenced clear with reads every cycle, a dropped write and an ignored clr
    clr = 1;
    set_rd(0, 31);
    step();
    for (int c = 0; c < 32; c++) begin
      set_rd(0, 5'(c)); set_rd(1, 3); set_rd(2, 31);
      if (c == 10) begin
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h0BAD0BAD;
      end
      if (c == 20) begin
        wr1_en = 1; wr1_addr = 30; wr1_data = 32'h0BADBEEF;
      end
      if (c == 5) clr = 1;
      step();
    end
    read_all();

    // four distinct values read in one cycle on all ports
    wr0_en = 1; wr0_addr = 10; wr0_data = 32'd1;
    wr1_en = 1; wr1_addr = 11; wr1_data = 32'd2;
    step();
    wr0_en = 1; wr0_addr = 12; wr0_data = 32'd3;
    wr1_en = 1; wr1_addr = 13; wr1_data = 32'd4;
    step();
    set_rd(0, 10); set_rd(1, 11); set_rd(2, 12); set_rd(3, 13);
    step();

    // reset in the middle of a clear
    wr0_en = 1; wr0_addr = 20; wr0_data = 32'h55;
    step();
    clr = 1;
    step();
    for (int c = 0; c < 10; c++) begin
      set_rd(0, 20); set_rd(1, 5'(c));
      step();
    end
    set_rd(0, 20);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    chk("abort_clr_busy", 32'(clr_busy), 32'd0);
    chk("abort_wr_drop", 32'(wr_drop), 32'd0);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("abort_rd_data%0d", k), rd_data[k*DW +: DW], '0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipeline's decode stage, replacing the fixed 32x32, two-read/one-write register file. It provides NUM_RD registered read ports and two write ports (WB and a second retire path), a hardwired zero register option, and a sequenced clear engine that zeroes the array one entry per cycle without asserting reset. An optional same-cycle write-to-read bypass is selected at compile time.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_valid  out  NUM_RD  per-port data-valid, 1-cycle pulse
- wr0_en, wr0_addr, wr0_data  in  1, ADDR_W, DATA_W  write port 0
- wr1_en, wr1_addr, wr1_data  in  1, ADDR_W, DATA_W  write port 1
- clr  in  1  start sequenced clear (pulse)
- clr_busy  out  1  clear in progress
- wr_drop  out  1  registered pulse: a write was discarded during clear

## Operation
- Reset (rst_n low, asynchronous): all entries 0, rd_data 0, rd_valid 0, clr_busy 0, wr_drop 0, FSM IDLE, clear counter 0.
- Write: wrX_en sampled at posedge commits wrX_data to wrX_addr. Same address on both ports in one cycle: port 1 wins. Writes to entry 0 are discarded when ZERO_REG=1.
- Read: rd_en[k] at posedge N loads rd_data[k] from rd_addr[k] and sets rd_valid[k] for the cycle after N. With rd_en[k] low, rd_valid[k] goes 0 and rd_data[k] holds its last value.
- Address 0 with ZERO_REG=1 reads 0 regardless of bypass.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr is sampled high. Counter loads 0.
  - CLEAR: each posedge zeroes entry[counter] and increments the counter.
  - CLEAR -> IDLE at the posedge that zeroes entry DEPTH-1. Counter wraps to 0.
  - clr in CLEAR is ignored.
- During CLEAR (clr_busy=1): all writes are dropped, and wr_drop pulses the next cycle for each cycle with any wrX_en. Reads complete with rd_valid=1 and rd_data=0.
- rst_n low mid-clear aborts immediately to the reset state.

## Timing
- Read latency: 1 cycle, from rd_en sampled to rd_valid/rd_data.
- Write visibility without bypass: reads sampled at the same edge return the old value. Reads one cycle later return the new value.
- clr sampled at edge N: clr_busy is high after edges N through N+DEPTH-1 and low after edge N+DEPTH. It is high for exactly DEPTH cycles.
- A read sampled at the edge where CLEAR exits to IDLE still returns 0.

## Configuration
- REGFILE_BYPASS_EN defined: a read sampled at the same edge as a matching write returns the new write data. If both write ports match, port 1 data is returned. Bypass is suppressed during CLEAR and for entry 0 when ZERO_REG=1.
- Undefined: no forwarding. Same-edge reads return pre-write contents; the hazard is left to the pipeline forwarding unit.

## Structure
- regfile_pkg: default DATA_W/ADDR_W/NUM_RD constants and the FSM state typedef (IDLE, CLEAR).
- Sub-module regfile_rd_port: one read port (array mux, zero-register force, optional bypass compare, output register). Instantiated NUM_RD times by generate.
- The storage array, write arbitration, clear FSM/counter and wr_drop logic stay in regfile_mp.

## Test plan
- Reset then read all 32 entries on both ports -> every rd_data = 0, rd_valid = 1 one cycle after each rd_en.
- wr0 writes 0xDEADBEEF to r5 and wr1 writes 0x12345678 to r5 in the same cycle; read r5 next cycle -> 0x12345678. Write 0xFFFFFFFF to r0, then read r0 -> 0.
- Write r7=0xA5A5A5A5 and read r7 at the same edge -> 0xA5A5A5A5 with REGFILE_BYPASS_EN defined, previous value 0 without it.
- Fill all entries with their index+1, pulse clr -> clr_busy high exactly 32 cycles. A write to r3 during clear gives a wr_drop pulse and r3 reads 0. All entries read 0 afterwards.
- Deassert rst_n asynchronously at clear count 10 with r20=0x55 -> outputs zero immediately, clr_busy 0, all entries read 0 after release.
- NUM_RD=4: read four distinct addresses holding 1, 2, 3, 4 in one cycle -> each port returns its own value with rd_valid=4'b1111.
